// File: rtl/gcd_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential GCD controller.
// The master drives operands and consumes results; the slave is the controller.
interface gcd_seq_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] gcd_out;
  logic [WIDTH-1:0] iter_out;
  logic             zero_err;

  modport master (
    output in_valid, a_in, b_in, abort, out_ready,
    input  in_ready, out_valid, gcd_out, iter_out, zero_err
  );

  modport slave (
    input  in_valid, a_in, b_in, abort, out_ready,
    output in_ready, out_valid, gcd_out, iter_out, zero_err
  );
endinterface

// File: rtl/gcd_seq_ctrl.sv
// Subtract-and-swap GCD controller: one compare/subtract step per clock,
// operands in and result out over valid/ready handshakes, abortable at any time.
module gcd_seq_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  gcd_seq_ctrl_if.slave  bus_io
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] iter_q;
  logic [WIDTH-1:0] gcd_q;
  logic [WIDTH-1:0] iter_out_q;
  logic             zero_err_q;
  logic             out_valid_q;
  logic             in_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      iter_q      <= '0;
      gcd_q       <= '0;
      iter_out_q  <= '0;
      zero_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (bus_io.abort) begin
      // Result registers keep their last values; only the handshake state is dropped.
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.in_valid) begin
            a_q        <= bus_io.a_in;
            b_q        <= bus_io.b_in;
            iter_q     <= '0;
            state_q    <= StRun;
            in_ready_q <= 1'b0;
          end
        end
        StRun: begin
          if (a_q == '0 || b_q == '0 || a_q == b_q) begin
            gcd_q       <= (a_q == '0) ? b_q : a_q;
            zero_err_q  <= (a_q == '0) && (b_q == '0);
            iter_out_q  <= iter_q;
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end else if (a_q > b_q) begin
            a_q    <= a_q - b_q;
            iter_q <= iter_q + 1'b1;
          end else begin
            b_q    <= b_q - a_q;
            iter_q <= iter_q + 1'b1;
          end
        end
        StDone: begin
          if (bus_io.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Hold in_ready low while reset is asserted, without waiting for a clock.
  assign bus_io.in_ready  = in_ready_q & rst_n;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.gcd_out   = gcd_q;
  assign bus_io.iter_out  = iter_out_q;
  assign bus_io.zero_err  = zero_err_q;

endmodule

// File: tb/tb_gcd_seq_ctrl.sv
// Bench for gcd_seq_ctrl: directed vector table, handshake corner sequences,
// and random operands checked against a Euclid-based reference model.
module tb_gcd_seq_ctrl;
  localparam int unsigned W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  gcd_seq_ctrl_if #(.WIDTH(W)) bus ();

  gcd_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int g;
    int i;
    int z;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int ref_gcd(input int a, input int b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Subtractive steps = sum of Euclid quotients, minus the final step to zero.
  function automatic int ref_iter(input int a, input int b);
    int x = a;
    int y = b;
    int s = 0;
    int t;
    if (a == 0 || b == 0) return 0;
    while (y != 0) begin
      s += x / y;
      t = x % y;
      x = y;
      y = t;
    end
    return s - 1;
  endfunction

  task automatic start_op(input int a, input int b);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", int'(bus.in_ready), 1);
    bus.a_in     = a[W-1:0];
    bus.b_in     = b[W-1:0];
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a_in     = W'($urandom);
    bus.b_in     = W'($urandom);
    chk("in_ready_after_accept", int'(bus.in_ready), 0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("out_valid_timeout", int'(bus.out_valid), 1);
  endtask

  task automatic release_result();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("out_valid_after_release", int'(bus.out_valid), 0);
    chk("in_ready_after_release", int'(bus.in_ready), 1);
  endtask

  task automatic do_op(input int a, input int b, input int g, input int i, input int z);
    int lat;
    start_op(a, b);
    wait_done(lat);
    chk("latency", lat, i + 1);
    chk("gcd_out", int'(bus.gcd_out), g);
    chk("iter_out", int'(bus.iter_out), i);
    chk("zero_err", int'(bus.zero_err), z);
    release_result();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    int ra;
    int rb;

    tbl[0] = '{a: 12, b: 8,  g: 4, i: 2,  z: 0};
    tbl[1] = '{a: 15, b: 1,  g: 1, i: 14, z: 0};
    tbl[2] = '{a: 9,  b: 9,  g: 9, i: 0,  z: 0};
    tbl[3] = '{a: 0,  b: 6,  g: 6, i: 0,  z: 0};
    tbl[4] = '{a: 0,  b: 0,  g: 0, i: 0,  z: 1};
    tbl[5] = '{a: 6,  b: 4,  g: 2, i: 2,  z: 0};
    tbl[6] = '{a: 7,  b: 0,  g: 7, i: 0,  z: 0};
    tbl[7] = '{a: 1,  b: 15, g: 1, i: 14, z: 0};
    tbl[8] = '{a: 14, b: 6,  g: 2, i: 4,  z: 0};
    tbl[9] = '{a: 10, b: 15, g: 5, i: 2,  z: 0};

    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("reset_in_ready", int'(bus.in_ready), 0);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_gcd_out", int'(bus.gcd_out), 0);
    chk("reset_iter_out", int'(bus.iter_out), 0);
    chk("reset_zero_err", int'(bus.zero_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", int'(bus.in_ready), 1);

    foreach (tbl[k]) do_op(tbl[k].a, tbl[k].b, tbl[k].g, tbl[k].i, tbl[k].z);

    // Result held in DONE while out_ready is low; in_valid pulse ignored
    start_op(12, 8);
    wait_done(lat);
    chk("hold_latency", lat, 3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.in_valid = (k == 2);
      bus.a_in     = 4'd3;
      bus.b_in     = 4'd3;
      @(posedge clk);
      #1;
      chk("hold_gcd_out", int'(bus.gcd_out), 4);
      chk("hold_iter_out", int'(bus.iter_out), 2);
      chk("hold_out_valid", int'(bus.out_valid), 1);
      chk("hold_in_ready", int'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    release_result();
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1;
    end
    chk("no_phantom_op_after_hold", seen, 0);

    // Abort during the third RUN cycle
    start_op(15, 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    chk("abort_in_ready", int'(bus.in_ready), 1);
    chk("abort_out_valid", int'(bus.out_valid), 0);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1;
    end
    chk("no_result_after_abort", seen, 0);
    do_op(6, 4, 2, 2, 0);

    // Asynchronous reset mid-RUN
    start_op(15, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", int'(bus.in_ready), 0);
    chk("async_rst_out_valid", int'(bus.out_valid), 0);
    chk("async_rst_gcd_out", int'(bus.gcd_out), 0);
    chk("async_rst_iter_out", int'(bus.iter_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_async_rst", int'(bus.in_ready), 1);
    do_op(12, 8, 4, 2, 0);

    // Random operands against the reference model
    repeat (40) begin
      ra = int'($urandom_range(0, 15));
      rb = int'($urandom_range(0, 15));
      do_op(ra, rb, ref_gcd(ra, rb), ref_iter(ra, rb), (ra == 0 && rb == 0) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
